// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of one combinational ALU: grant, register operands, capture result, respond.
// Optional build macro ALU_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins ties) instead of round-robin.
module alu_share_arbiter #(
    parameter int DATAWIDTH   = 32,
    parameter int SHIFT_WIDTH = 5,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               req_valid_i,
    output logic [1:0]               req_ready_o,
    input  logic [2*DATAWIDTH-1:0]   req_srca_i,
    input  logic [2*DATAWIDTH-1:0]   req_srcb_i,
    input  logic [7:0]               req_aluctrl_i,
    input  logic [5:0]               req_branchctrl_i,
    input  logic [2*SHIFT_WIDTH-1:0] req_shift_i,
    output logic [DATAWIDTH-1:0]     alu_srca_o,
    output logic [DATAWIDTH-1:0]     alu_srcb_o,
    output logic [3:0]               alu_ctrl_o,
    output logic [2:0]               alu_branchctrl_o,
    output logic [SHIFT_WIDTH-1:0]   alu_shift_o,
    input  logic [DATAWIDTH-1:0]     alu_result_i,
    input  logic                     alu_branch_i,
    output logic [1:0]               rsp_valid_o,
    input  logic [1:0]               rsp_ready_i,
    output logic [DATAWIDTH-1:0]     rsp_result_o,
    output logic                     rsp_branch_o,
    output logic                     busy_o,
    output logic [CNT_WIDTH-1:0]     ops_done_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t r_state;
    state_t w_state_next;
    logic   r_owner;
    logic   w_grant_valid;
    logic   w_grant;
    logic   w_rsp_done;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic   r_last_grant;
`endif

    // Grant selection, only meaningful while idle
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = 1'b0;
        if (r_state == ST_IDLE) begin
            case (req_valid_i)
                2'b01: begin
                    w_grant_valid = 1'b1;
                    w_grant       = 1'b0;
                end
                2'b10: begin
                    w_grant_valid = 1'b1;
                    w_grant       = 1'b1;
                end
                2'b11: begin
                    w_grant_valid = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
                    w_grant       = 1'b0;
`else
                    w_grant       = ~r_last_grant;
`endif
                end
                default: begin
                    w_grant_valid = 1'b0;
                    w_grant       = 1'b0;
                end
            endcase
        end else begin
            w_grant_valid = 1'b0;
            w_grant       = 1'b0;
        end
    end

    assign req_ready_o = w_grant_valid ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
    assign w_rsp_done  = (r_state == ST_RESP) && rsp_ready_i[r_owner];
    assign busy_o      = (r_state != ST_IDLE);

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_state_next = ST_EXEC;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_EXEC: w_state_next = ST_RESP;
            ST_RESP: begin
                if (w_rsp_done) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_RESP;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand capture on the accept edge; held afterwards, including in idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_srca_o       <= {DATAWIDTH{1'b0}};
            alu_srcb_o       <= {DATAWIDTH{1'b0}};
            alu_ctrl_o       <= 4'd0;
            alu_branchctrl_o <= 3'd0;
            alu_shift_o      <= {SHIFT_WIDTH{1'b0}};
            r_owner          <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_last_grant     <= 1'b1;
`endif
        end else if (w_grant_valid) begin
            alu_srca_o       <= w_grant ? req_srca_i[2*DATAWIDTH-1:DATAWIDTH] : req_srca_i[DATAWIDTH-1:0];
            alu_srcb_o       <= w_grant ? req_srcb_i[2*DATAWIDTH-1:DATAWIDTH] : req_srcb_i[DATAWIDTH-1:0];
            alu_ctrl_o       <= w_grant ? req_aluctrl_i[7:4] : req_aluctrl_i[3:0];
            alu_branchctrl_o <= w_grant ? req_branchctrl_i[5:3] : req_branchctrl_i[2:0];
            alu_shift_o      <= w_grant ? req_shift_i[2*SHIFT_WIDTH-1:SHIFT_WIDTH] : req_shift_i[SHIFT_WIDTH-1:0];
            r_owner          <= w_grant;
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_last_grant     <= w_grant;
`endif
        end else begin
            r_owner          <= r_owner;
        end
    end

    // Response capture at the end of the single execute cycle, held until the owner takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result_o <= {DATAWIDTH{1'b0}};
            rsp_branch_o <= 1'b0;
            rsp_valid_o  <= 2'b00;
        end else if (r_state == ST_EXEC) begin
            rsp_result_o <= alu_result_i;
            rsp_branch_o <= alu_branch_i;
            rsp_valid_o  <= r_owner ? 2'b10 : 2'b01;
        end else if (w_rsp_done) begin
            rsp_valid_o  <= 2'b00;
        end else begin
            rsp_valid_o  <= rsp_valid_o;
        end
    end

    // Completed-response counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_done_o <= {CNT_WIDTH{1'b0}};
        end else if (w_rsp_done) begin
            ops_done_o <= ops_done_o + CNT_ONE;
        end else begin
            ops_done_o <= ops_done_o;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: transaction-level model plus directed literal checks.
module tb_alu_share_arbiter;
    localparam int DW = 32;
    localparam int SW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_valid_i;
    logic [1:0]    req_ready_o;
    logic [2*DW-1:0] req_srca_i, req_srcb_i;
    logic [7:0]    req_aluctrl_i;
    logic [5:0]    req_branchctrl_i;
    logic [2*SW-1:0] req_shift_i;
    logic [DW-1:0] alu_srca_o, alu_srcb_o, alu_result_i, rsp_result_o;
    logic [3:0]    alu_ctrl_o;
    logic [2:0]    alu_branchctrl_o;
    logic [SW-1:0] alu_shift_o;
    logic          alu_branch_i, rsp_branch_o, busy_o;
    logic [1:0]    rsp_valid_o, rsp_ready_i;
    logic [CW-1:0] ops_done_o;

    int n_tests = 0;
    int n_fail  = 0;

    alu_share_arbiter #(.DATAWIDTH(DW), .SHIFT_WIDTH(SW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_srca_i(req_srca_i), .req_srcb_i(req_srcb_i),
        .req_aluctrl_i(req_aluctrl_i), .req_branchctrl_i(req_branchctrl_i), .req_shift_i(req_shift_i),
        .alu_srca_o(alu_srca_o), .alu_srcb_o(alu_srcb_o), .alu_ctrl_o(alu_ctrl_o),
        .alu_branchctrl_o(alu_branchctrl_o), .alu_shift_o(alu_shift_o),
        .alu_result_i(alu_result_i), .alu_branch_i(alu_branch_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_branch_o(rsp_branch_o),
        .busy_o(busy_o), .ops_done_o(ops_done_o)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_res(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [3:0] c);
        return (c == 4'd0) ? a + b : a - b;
    endfunction

    function automatic logic alu_br(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [3:0] c);
        return (c == 4'd0) ? (a == b) : (a < b);
    endfunction

    // Combinational ALU stand-in
    always_comb begin
        alu_result_i = alu_res(alu_srca_o, alu_srcb_o, alu_ctrl_o);
        alu_branch_i = alu_br(alu_srca_o, alu_srcb_o, alu_ctrl_o);
    end

    // Reference model: one transaction in flight, response visible from the cycle after execute
    function automatic int mgrant(input logic [1:0] v, input logic last);
        if (v == 2'b00) return -1;
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        return 0;
`else
        return last ? 0 : 1;
`endif
    endfunction

    logic          m_active, m_age, m_owner, m_last, m_br, m_pbr;
    logic [CW-1:0] m_ops;
    logic [DW-1:0] m_res, m_pres, m_a, m_b;
    logic [3:0]    m_ctrl;
    logic [2:0]    m_bctrl;
    logic [SW-1:0] m_sh;

    // Model update on each clock edge / async reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0; m_age <= 1'b0; m_owner <= 1'b0; m_last <= 1'b1;
            m_ops <= '0; m_res <= '0; m_br <= 1'b0; m_pres <= '0; m_pbr <= 1'b0;
            m_a <= '0; m_b <= '0; m_ctrl <= '0; m_bctrl <= '0; m_sh <= '0;
        end else if (!m_active) begin
            if (mgrant(req_valid_i, m_last) >= 0) begin
                if (mgrant(req_valid_i, m_last) == 1) begin
                    m_a <= req_srca_i[63:32]; m_b <= req_srcb_i[63:32];
                    m_ctrl <= req_aluctrl_i[7:4]; m_bctrl <= req_branchctrl_i[5:3]; m_sh <= req_shift_i[9:5];
                    m_pres <= alu_res(req_srca_i[63:32], req_srcb_i[63:32], req_aluctrl_i[7:4]);
                    m_pbr  <= alu_br(req_srca_i[63:32], req_srcb_i[63:32], req_aluctrl_i[7:4]);
                    m_owner <= 1'b1; m_last <= 1'b1;
                end else begin
                    m_a <= req_srca_i[31:0]; m_b <= req_srcb_i[31:0];
                    m_ctrl <= req_aluctrl_i[3:0]; m_bctrl <= req_branchctrl_i[2:0]; m_sh <= req_shift_i[4:0];
                    m_pres <= alu_res(req_srca_i[31:0], req_srcb_i[31:0], req_aluctrl_i[3:0]);
                    m_pbr  <= alu_br(req_srca_i[31:0], req_srcb_i[31:0], req_aluctrl_i[3:0]);
                    m_owner <= 1'b0; m_last <= 1'b0;
                end
                m_active <= 1'b1; m_age <= 1'b0;
            end
        end else if (!m_age) begin
            m_age <= 1'b1; m_res <= m_pres; m_br <= m_pbr;
        end else if (rsp_ready_i[m_owner]) begin
            m_active <= 1'b0; m_ops <= m_ops + 4'd1;
        end
    end

    function automatic logic [1:0] exp_ready();
        int g;
        if (m_active) return 2'b00;
        g = mgrant(req_valid_i, m_last);
        if (g < 0) return 2'b00;
        return (g == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        #1;
        chk("m_req_ready", {62'd0, req_ready_o}, {62'd0, exp_ready()});
        chk("m_rsp_valid", {62'd0, rsp_valid_o}, {62'd0, (m_active && m_age) ? (m_owner ? 2'b10 : 2'b01) : 2'b00});
        chk("m_busy", {63'd0, busy_o}, {63'd0, m_active});
        chk("m_ops", {60'd0, ops_done_o}, {60'd0, m_ops});
        chk("m_result", {32'd0, rsp_result_o}, {32'd0, m_res});
        chk("m_branch", {63'd0, rsp_branch_o}, {63'd0, m_br});
        chk("m_alu_a", {32'd0, alu_srca_o}, {32'd0, m_a});
        chk("m_alu_b", {32'd0, alu_srcb_o}, {32'd0, m_b});
        chk("m_alu_ctl", {52'd0, alu_ctrl_o, alu_branchctrl_o, alu_shift_o}, {52'd0, m_ctrl, m_bctrl, m_sh});
    end

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        if (k == 1) begin
            req_srca_i[63:32] = a; req_srcb_i[63:32] = b; req_aluctrl_i[7:4] = c;
            req_branchctrl_i[5:3] = 3'd5; req_shift_i[9:5] = a[4:0];
        end else begin
            req_srca_i[31:0] = a; req_srcb_i[31:0] = b; req_aluctrl_i[3:0] = c;
            req_branchctrl_i[2:0] = 3'd2; req_shift_i[4:0] = b[4:0];
        end
    endtask

    int gq[$];
    int exp_g[4];

    initial begin
        rst_n = 1'b0; req_valid_i = 2'b00; rsp_ready_i = 2'b00;
        req_srca_i = '0; req_srcb_i = '0; req_aluctrl_i = '0; req_branchctrl_i = '0; req_shift_i = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("reset_ops", {60'd0, ops_done_o}, 64'd0);
        chk("reset_rsp_valid", {62'd0, rsp_valid_o}, 64'd0);
        chk("reset_busy", {63'd0, busy_o}, 64'd0);
        chk("reset_alu_a", {32'd0, alu_srca_o}, 64'd0);

        // Single request 5+7
        @(negedge clk); set_req(0, 32'd5, 32'd7, 4'd0); req_valid_i = 2'b01;
        #2; chk("single_ready", {62'd0, req_ready_o}, 64'd1);
        @(negedge clk); req_valid_i = 2'b00;
        #2; chk("single_busy", {63'd0, busy_o}, 64'd1); chk("single_notyet", {62'd0, rsp_valid_o}, 64'd0);
        @(negedge clk); rsp_ready_i = 2'b01;
        #2; chk("single_valid", {62'd0, rsp_valid_o}, 64'd1);
        chk("single_result", {32'd0, rsp_result_o}, 64'd12); chk("single_branch", {63'd0, rsp_branch_o}, 64'd0);
        @(negedge clk); #2; chk("single_ops", {60'd0, ops_done_o}, 64'd1);

        // Non-owner ready is ignored
        @(negedge clk); set_req(0, 32'd3, 32'd3, 4'd0); req_valid_i = 2'b01; rsp_ready_i = 2'b10;
        @(negedge clk); req_valid_i = 2'b00;
        repeat (3) begin
            @(negedge clk); #2;
            chk("nonown_valid", {62'd0, rsp_valid_o}, 64'd1);
            chk("nonown_ops", {60'd0, ops_done_o}, 64'd1);
        end
        chk("nonown_result", {32'd0, rsp_result_o}, 64'd6);
        @(negedge clk); rsp_ready_i = 2'b01;
        @(negedge clk); #2; chk("nonown_ops2", {60'd0, ops_done_o}, 64'd2);

        // Response backpressure on requester 1, requester 0 waiting
        @(negedge clk); rsp_ready_i = 2'b00; set_req(1, 32'd9, 32'd9, 4'd0); req_valid_i = 2'b10;
        #2; chk("bp_ready1", {62'd0, req_ready_o}, 64'd2);
        @(negedge clk); set_req(0, 32'd1, 32'd2, 4'd0); req_valid_i = 2'b01;
        #2; chk("bp_exec_ready", {62'd0, req_ready_o}, 64'd0);
        repeat (5) begin
            @(negedge clk); #2;
            chk("bp_valid", {62'd0, rsp_valid_o}, 64'd2);
            chk("bp_result", {32'd0, rsp_result_o}, 64'd18);
            chk("bp_branch", {63'd0, rsp_branch_o}, 64'd1);
            chk("bp_ready0", {62'd0, req_ready_o}, 64'd0);
        end
        @(negedge clk); rsp_ready_i = 2'b10;
        #2; chk("bp_hs_ready", {62'd0, req_ready_o}, 64'd0);
        @(negedge clk); rsp_ready_i = 2'b01;
        #2; chk("bp_after_valid", {62'd0, rsp_valid_o}, 64'd0); chk("bp_after_ready", {62'd0, req_ready_o}, 64'd1);
        @(negedge clk); req_valid_i = 2'b00;
        @(negedge clk); #2; chk("bp_r0_result", {32'd0, rsp_result_o}, 64'd3);
        @(negedge clk); #2; chk("bp_ops", {60'd0, ops_done_o}, 64'd4);

        // Asynchronous reset during execute
        @(negedge clk); rsp_ready_i = 2'b00; set_req(0, 32'd4, 32'd4, 4'd1); req_valid_i = 2'b01;
        @(negedge clk); req_valid_i = 2'b00;
        #3; rst_n = 1'b0;
        #1;
        chk("ar_busy", {63'd0, busy_o}, 64'd0); chk("ar_valid", {62'd0, rsp_valid_o}, 64'd0);
        chk("ar_alu_a", {32'd0, alu_srca_o}, 64'd0); chk("ar_ops", {60'd0, ops_done_o}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk); #2; chk("ar_no_rsp", {62'd0, rsp_valid_o}, 64'd0);
        end
        @(negedge clk); set_req(0, 32'd10, 32'd20, 4'd0); req_valid_i = 2'b01;
        @(negedge clk); req_valid_i = 2'b00;
        @(negedge clk); rsp_ready_i = 2'b01;
        #2; chk("ar_next_result", {32'd0, rsp_result_o}, 64'd30);
        @(negedge clk); #2; chk("ar_next_ops", {60'd0, ops_done_o}, 64'd1);

        // Tie arbitration from reset
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        set_req(0, 32'd1, 32'd1, 4'd0); set_req(1, 32'd100, 32'd28, 4'd1);
        req_valid_i = 2'b11; rsp_ready_i = 2'b11;
        for (int i = 0; i < 12; i++) begin
            #2;
            if (req_ready_o == 2'b01) gq.push_back(0);
            else if (req_ready_o == 2'b10) gq.push_back(1);
            @(negedge clk);
        end
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0};
`else
        exp_g = '{0, 1, 0, 1};
`endif
        chk("tie_count", 64'(gq.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("tie_order", 64'(gq[i]), 64'(exp_g[i]));
        end
        req_valid_i = 2'b01; rsp_ready_i = 2'b01;
        #2; chk("tie_ops", {60'd0, ops_done_o}, 64'd4);

        // Counter wrap: 12 more ops bring the 4-bit count from 4 back to 0
        for (int i = 0; i < 36; i++) begin
            set_req(0, 32'(i), 32'(2 * i), 4'(i % 2));
            @(negedge clk);
        end
        req_valid_i = 2'b00;
        #2; chk("wrap_ops", {60'd0, ops_done_o}, 64'd0);
        @(negedge clk); @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
